// File: rtl/lsu_dcache_if_if.sv
// lsu_dcache_if_if: bundles for the LSU's pipeline-side and cache-side ports.
//   lsu_mem_if : MEM-stage request/response (master = pipeline, slave = LSU)
//   lsu_cpu_if : D-cache CPU port (master = LSU, slave = cache)
interface lsu_mem_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
   logic              mem_req;
   logic              mem_ready;
   logic              mem_we;
   logic [2:0]        mem_funct3;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_done;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_exc;
   logic [1:0]        mem_exc_cause;
   modport master (output mem_req, mem_we, mem_funct3, mem_addr, mem_wdata,
                   input  mem_ready, mem_done, mem_rdata, mem_exc, mem_exc_cause);
   modport slave  (input  mem_req, mem_we, mem_funct3, mem_addr, mem_wdata,
                   output mem_ready, mem_done, mem_rdata, mem_exc, mem_exc_cause);
endinterface

interface lsu_cpu_if #(parameter int DATA_W = 32, parameter int ADDR_W = 32);
   logic                cpu_req;
   logic [ADDR_W-1:0]   cpu_req_addr;
   logic                cpu_wr_en;
   logic [DATA_W-1:0]   cpu_wr_data;
   logic [DATA_W/8-1:0] cpu_wr_strb;
   logic                cpu_req_valid;
   logic [DATA_W-1:0]   cpu_req_data;
   logic                busy;
   modport master (output cpu_req, cpu_req_addr, cpu_wr_en, cpu_wr_data, cpu_wr_strb,
                   input  cpu_req_valid, cpu_req_data, busy);
   modport slave  (input  cpu_req, cpu_req_addr, cpu_wr_en, cpu_wr_data, cpu_wr_strb,
                   output cpu_req_valid, cpu_req_data, busy);
endinterface

// File: rtl/lsu_dcache_if.sv
// lsu_dcache_if: MEM-stage load/store unit in front of the D-cache CPU port.
//   ACLK/ARESETn : clock, asynchronous active-low reset
//   mem (slave)  : pipeline request (we/funct3/addr/wdata), ready, done pulse,
//                  extended load data, exception pulse and held cause
//   cpu (master) : word-aligned cache request with strobes, completion/read
//                  data and the cache busy indication
module lsu_dcache_if #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int TIMEOUT_CYC = 1024,
   parameter int TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
   input logic       ACLK,
   input logic       ARESETn,
   lsu_mem_if.slave  mem,
   lsu_cpu_if.master cpu
);
   localparam int CW = (TO_W < 1) ? 1 : TO_W;
   typedef enum logic [1:0] {IDLE, ISSUE, REQ, DONE} state_t;
   state_t            state, state_nx;
   logic              we_q, exc_q;
   logic [2:0]        f3_q;
   logic [1:0]        cause_q, b;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q, lane, ext;
   logic [CW-1:0]     cnt;
   logic              accept, illegal, misalign, to_hit;
   assign accept   = mem.mem_req && state == IDLE;
   assign illegal  = (mem.mem_funct3 inside {3'b011, 3'b110, 3'b111}) || (mem.mem_we && mem.mem_funct3[2]);
   assign misalign = (mem.mem_funct3[1:0] == 2'b01 && mem.mem_addr[0]) ||
                     (mem.mem_funct3[1:0] == 2'b10 && mem.mem_addr[1:0] != 2'b00);
   assign to_hit   = (TIMEOUT_CYC != 0) && (cnt == CW'(TIMEOUT_CYC - 1));
   assign b        = addr_q[1:0];
   assign lane     = cpu.cpu_req_data >> {b, 3'b000};
   // funct3[2] selects zero extension (BU/HU); funct3[1:0] selects the size
   assign ext = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lane[7]}}, lane[7:0]} :
                f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lane[15]}}, lane[15:0]} : lane;
   always_comb begin
      state_nx          = state;
      mem.mem_ready     = state == IDLE;
      mem.mem_done      = state == DONE;
      cpu.cpu_req       = state == REQ;
      cpu.cpu_wr_en     = state == REQ && we_q;
      mem.mem_rdata     = rdata_q;
      mem.mem_exc       = exc_q;
      mem.mem_exc_cause = cause_q;
      cpu.cpu_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};
      cpu.cpu_wr_data   = !we_q ? '0 : f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} :
                          f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
      cpu.cpu_wr_strb   = !we_q ? 4'b0000 : f3_q[1:0] == 2'b00 ? 4'b0001 << b :
                          f3_q[1:0] == 2'b01 ? 4'b0011 << b : 4'b1111;
      unique case (state)
         // an idle cache at accept skips the ISSUE wait so CPU_REQ rises the next cycle
         IDLE:  if (accept && !illegal && !misalign) state_nx = cpu.busy ? ISSUE : REQ;
         ISSUE: if (!cpu.busy) state_nx = REQ;
         REQ:   state_nx = cpu.cpu_req_valid ? DONE : to_hit ? IDLE : REQ;
         DONE:  state_nx = IDLE;
      endcase
   end
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state   <= IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         exc_q   <= 1'b0;
         cause_q <= '0;
         cnt     <= '0;
      end else begin
         state <= state_nx;
         exc_q <= 1'b0;
         cnt   <= state == REQ ? cnt + 1'b1 : '0;
         if (accept) begin
            we_q    <= mem.mem_we;
            f3_q    <= mem.mem_funct3;
            addr_q  <= mem.mem_addr;
            wdata_q <= mem.mem_wdata;
         end
         if (accept && (illegal || misalign)) begin
            exc_q   <= 1'b1;
            cause_q <= illegal ? 2'b10 : 2'b01;
         end
         if (state == REQ && cpu.cpu_req_valid && !we_q) rdata_q <= ext;
         // completion on the terminal-count cycle takes priority over the watchdog
         if (state == REQ && !cpu.cpu_req_valid && to_hit) begin
            exc_q   <= 1'b1;
            cause_q <= 2'b11;
         end
      end
   end
endmodule
